// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the RV32I next-PC stage.
// Redirect kinds, FSM state encoding and the instruction step size.
package pc_pkg;

    typedef enum logic [1:0] {
        BR       = 2'd0,
        JAL      = 2'd1,
        JALR     = 2'd2,
        KIND_ILL = 2'd3
    } redir_kind_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

    localparam int INSTR_BYTES = 4;

    function automatic logic kind_legal(input redir_kind_t kind);
        return kind != KIND_ILL;
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Bundle between the EX-stage resolve logic / fetch and the next-PC stage.
// The master drives redirect/stall/trap requests; the slave (pc_next_unit) returns the fetch PC.
interface pc_next_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             redir_valid_i;
    logic [1:0]       redir_kind_i;
    logic [XLEN-1:0]  redir_base_i;
    logic [XLEN-1:0]  redir_rs1_i;
    logic [XLEN-1:0]  redir_imm_i;
    logic             trap_i;

    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  pc_plus4_o;
    logic             flush_o;
    logic             misalign_o;
    logic [XLEN-1:0]  bad_addr_o;
    logic [CNT_W-1:0] redir_cnt_o;

    modport master (
        output stall_i, redir_valid_i, redir_kind_i, redir_base_i,
               redir_rs1_i, redir_imm_i, trap_i,
        input  pc_o, pc_plus4_o, flush_o, misalign_o, bad_addr_o, redir_cnt_o
    );

    modport slave (
        input  stall_i, redir_valid_i, redir_kind_i, redir_base_i,
               redir_rs1_i, redir_imm_i, trap_i,
        output pc_o, pc_plus4_o, flush_o, misalign_o, bad_addr_o, redir_cnt_o
    );

endinterface

// File: rtl/pc_next_unit_target_calc.sv
// Combinational redirect target: base+imm for BR/JAL, (rs1+imm)&~1 for JALR,
// plus the misalignment flag for the configured instruction alignment.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  redir_kind_t     i_kind,
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_tgt,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_reg_rel;

    assign w_pc_rel  = i_base + i_imm;
    assign w_reg_rel = (i_rs1 + i_imm) & ~XLEN'(1);
    assign o_tgt     = (i_kind == JALR) ? w_reg_rel : w_pc_rel;

    // Compressed-capable cores only require halfword alignment.
    generate
        if (IALIGN == 16) begin : g_align16
            assign o_misaligned = o_tgt[0];
        end else begin : g_align32
            assign o_misaligned = |o_tgt[1:0];
        end
    endgenerate

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC stage: owns the fetch PC, applies redirects/traps with priority,
// parks a redirect that lands during a fetch stall and traps misaligned targets.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100),
    parameter int              IALIGN   = 32,
    parameter int              CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_next_unit_if.slave  bus
);

    pc_state_t        r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_pend_tgt;
    logic [XLEN-1:0]  r_bad_addr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    pc_state_t        w_state_next;
    redir_kind_t      w_kind;
    logic [XLEN-1:0]  w_tgt;
    logic             w_tgt_misaligned;
    logic             w_redir_ok;
    logic             w_event;
    logic             w_fault;
    logic [XLEN-1:0]  w_eff_tgt;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_pend_load;
    logic             w_flush;
    logic             w_cnt_sat;

    assign w_kind = redir_kind_t'(bus.redir_kind_i);

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .i_kind       (w_kind),
        .i_base       (bus.redir_base_i),
        .i_rs1        (bus.redir_rs1_i),
        .i_imm        (bus.redir_imm_i),
        .o_tgt        (w_tgt),
        .o_misaligned (w_tgt_misaligned)
    );

    // A trap outranks a same-cycle redirect and is never itself checked for alignment.
    assign w_redir_ok = bus.redir_valid_i && kind_legal(w_kind);
    assign w_event    = bus.trap_i || w_redir_ok;
    assign w_fault    = !bus.trap_i && w_redir_ok && w_tgt_misaligned;
    assign w_eff_tgt  = (bus.trap_i || w_fault) ? TRAP_VEC : w_tgt;
    assign w_cnt_sat  = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            r_state <= w_state_next;
        end
    end

    always_comb begin : next_state
        // NOTE: default first so no path through the case leaves the target unassigned (latch).
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (w_event && bus.stall_i) w_state_next = PEND;
            PEND:    if (!bus.stall_i)           w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin : outputs
        w_flush     = w_event;
        w_pend_load = w_event && bus.stall_i;
        w_pc_next   = r_pc;
        if (!bus.stall_i) begin
            if (w_event) begin
                w_pc_next = w_eff_tgt;
            end else if (r_state == PEND) begin
                w_pc_next = r_pend_tgt;
            end else begin
                w_pc_next = r_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath_regs
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pend_tgt <= '0;
            r_bad_addr <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= w_fault;
            if (w_pend_load) r_pend_tgt <= w_eff_tgt;
            if (w_fault)     r_bad_addr <= w_tgt;
            if (w_event && !w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_o        = r_pc;
    assign bus.pc_plus4_o  = r_pc + XLEN'(INSTR_BYTES);
    assign bus.flush_o     = w_flush;
    assign bus.misalign_o  = r_misalign;
    assign bus.bad_addr_o  = r_bad_addr;
    assign bus.redir_cnt_o = r_cnt;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: two instances (IALIGN=32/CNT_W=2 and IALIGN=16/CNT_W=16)
// share one stimulus stream; a rule-level model predicts each cycle's outputs.
module tb_pc_next_unit;

    localparam longint M32 = 64'h1_0000_0000;
    localparam longint TV  = 64'h100;

    typedef struct {
        bit     stall;
        bit     valid;
        bit     trap;
        int     kind;
        longint base;
        longint rs1;
        longint imm;
    } stim_t;

    typedef struct {
        longint pc;
        bit     pend;
        longint pval;
        bit     mis;
        longint bad;
        longint cnt;
        int     ialign;
        longint cmax;
    } model_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        flush;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    bit   done;

    exp_t   q_a[$];
    exp_t   q_b[$];
    model_t ma;
    model_t mb;

    pc_next_unit_if #(.XLEN(32), .CNT_W(2))  bus_a ();
    pc_next_unit_if #(.XLEN(32), .CNT_W(16)) bus_b ();

    pc_next_unit #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .IALIGN(32), .CNT_W(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    pc_next_unit #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .IALIGN(16), .CNT_W(16))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_b.stall_i       = bus_a.stall_i;
    assign bus_b.redir_valid_i = bus_a.redir_valid_i;
    assign bus_b.redir_kind_i  = bus_a.redir_kind_i;
    assign bus_b.redir_base_i  = bus_a.redir_base_i;
    assign bus_b.redir_rs1_i   = bus_a.redir_rs1_i;
    assign bus_b.redir_imm_i   = bus_a.redir_imm_i;
    assign bus_b.trap_i        = bus_a.trap_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic model_t m_reset(input int ialign, input longint cmax);
        model_t m;
        m.pc = 0; m.pend = 0; m.pval = 0; m.mis = 0; m.bad = 0; m.cnt = 0;
        m.ialign = ialign; m.cmax = cmax;
        return m;
    endfunction

    function automatic bit is_event(input stim_t s);
        return s.trap || (s.valid && s.kind != 3);
    endfunction

    function automatic model_t m_step(input model_t m, input stim_t s);
        longint tgt, eff;
        bit     legal, ev, fault;
        legal = s.valid && s.kind != 3;
        ev    = is_event(s);
        if (s.kind == 2) begin
            tgt = (s.rs1 + s.imm) % M32;
            tgt = tgt - (tgt % 2);
        end else begin
            tgt = (s.base + s.imm) % M32;
        end
        fault = !s.trap && legal && ((tgt % (m.ialign / 8)) != 0);
        eff   = (s.trap || fault) ? TV : tgt;
        m.mis = fault;
        if (fault) m.bad = tgt;
        if (ev && m.cnt < m.cmax) m.cnt++;
        if (ev) begin
            if (s.stall) begin m.pend = 1; m.pval = eff; end
            else begin m.pc = eff; m.pend = 0; end
        end else if (!s.stall) begin
            if (m.pend) begin m.pc = m.pval; m.pend = 0; end
            else m.pc = (m.pc + 4) % M32;
        end
        return m;
    endfunction

    function automatic exp_t m_obs(input model_t m, input stim_t s);
        exp_t e;
        e.pc    = m.pc[31:0];
        e.pcp4  = ((m.pc + 4) % M32) & 64'hFFFF_FFFF;
        e.flush = is_event(s);
        e.mis   = m.mis;
        e.bad   = m.bad[31:0];
        e.cnt   = m.cnt[31:0];
        return e;
    endfunction

    // ---------------- driver ----------------
    function automatic stim_t mk(input bit stall, input bit valid, input int kind,
                                 input longint base, input longint rs1, input longint imm,
                                 input bit trap);
        stim_t s;
        s.stall = stall; s.valid = valid; s.kind = kind; s.trap = trap;
        s.base = base & 64'hFFFF_FFFF; s.rs1 = rs1 & 64'hFFFF_FFFF; s.imm = imm & 64'hFFFF_FFFF;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus_a.stall_i       = s.stall;
        bus_a.redir_valid_i = s.valid;
        bus_a.redir_kind_i  = s.kind[1:0];
        bus_a.redir_base_i  = s.base[31:0];
        bus_a.redir_rs1_i   = s.rs1[31:0];
        bus_a.redir_imm_i   = s.imm[31:0];
        bus_a.trap_i        = s.trap;
    endtask

    task automatic do_cycle(input stim_t s);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(s);
        q_a.push_back(m_obs(ma, s));
        q_b.push_back(m_obs(mb, s));
        ma = m_step(ma, s);
        mb = m_step(mb, s);
    endtask

    task automatic do_reset();
        stim_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        apply(idle);
        rst_n = 1'b0;
        ma = m_reset(32, 3);
        mb = m_reset(16, 65535);
        q_a.push_back(m_obs(ma, idle));
        q_b.push_back(m_obs(mb, idle));
    endtask

    task automatic idle_cycles(input int n, input bit stall);
        for (int i = 0; i < n; i++) do_cycle(mk(stall, 0, 0, 0, 0, 0, 0));
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a.pc_o",        bus_a.pc_o,                e.pc);
                check("a.pc_plus4_o",  bus_a.pc_plus4_o,          e.pcp4);
                check("a.flush_o",     32'(bus_a.flush_o),        32'(e.flush));
                check("a.misalign_o",  32'(bus_a.misalign_o),     32'(e.mis));
                check("a.bad_addr_o",  bus_a.bad_addr_o,          e.bad);
                check("a.redir_cnt_o", 32'(bus_a.redir_cnt_o),    e.cnt);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b.pc_o",        bus_b.pc_o,                e.pc);
                check("b.pc_plus4_o",  bus_b.pc_plus4_o,          e.pcp4);
                check("b.flush_o",     32'(bus_b.flush_o),        32'(e.flush));
                check("b.misalign_o",  32'(bus_b.misalign_o),     32'(e.mis));
                check("b.bad_addr_o",  bus_b.bad_addr_o,          e.bad);
                check("b.redir_cnt_o", 32'(bus_b.redir_cnt_o),    e.cnt);
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        stim_t s;
        n_checks = 0;
        n_errors = 0;
        done     = 0;
        rst_n    = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0));
        ma = m_reset(32, 3);
        mb = m_reset(16, 65535);
        repeat (2) @(posedge clk);

        // Sequential fetch from reset.
        idle_cycles(4, 0);
        // BR base=0x40 imm=-8.
        do_cycle(mk(0, 1, 0, 'h40, 0, -8, 0));
        idle_cycles(2, 0);
        // JALR rs1=0x1001 imm=2 held under a 3-cycle stall, then released.
        do_cycle(mk(1, 1, 2, 'h0, 'h1001, 2, 0));
        idle_cycles(2, 1);
        idle_cycles(3, 0);
        // JAL base=0x10 imm=6: faults for 32-bit alignment only.
        do_cycle(mk(0, 1, 1, 'h10, 0, 6, 0));
        idle_cycles(3, 0);
        // Trap and BR in the same cycle.
        do_cycle(mk(0, 1, 0, 'h200, 0, 'h40, 1));
        idle_cycles(1, 0);
        // Several more events to drive the narrow counter into saturation.
        for (int i = 0; i < 5; i++) do_cycle(mk(0, 1, 0, 'h80 + 16 * i, 0, 8, 0));
        idle_cycles(1, 0);
        // Illegal kind: ignored.
        do_cycle(mk(0, 1, 3, 'h300, 0, 'h40, 0));
        idle_cycles(1, 0);
        // Overwrite while pending: last accepted wins; also an illegal kind while pending.
        do_cycle(mk(1, 1, 0, 'h400, 0, 'h20, 0));
        do_cycle(mk(1, 1, 1, 'h500, 0, 'h40, 0));
        do_cycle(mk(1, 1, 3, 'h600, 0, 'h40, 0));
        do_cycle(mk(0, 0, 0, 0, 0, 0, 0));
        idle_cycles(2, 0);
        // New event in the same cycle the stall releases.
        do_cycle(mk(1, 1, 0, 'h700, 0, 'h10, 0));
        do_cycle(mk(0, 1, 0, 'h800, 0, 'h24, 0));
        idle_cycles(2, 0);
        // Wrap-around target.
        do_cycle(mk(0, 1, 0, 'hFFFF_FFF0, 0, 'h20, 0));
        idle_cycles(2, 0);
        // Reset while pending: pending target must be discarded.
        do_cycle(mk(1, 1, 0, 'h900, 0, 'h40, 0));
        idle_cycles(1, 1);
        do_reset();
        idle_cycles(4, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int im;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                s.stall = ($urandom_range(0, 99) < 40);
                s.valid = ($urandom_range(0, 99) < 35);
                s.trap  = ($urandom_range(0, 99) < 6);
                s.kind  = int'($urandom_range(0, 3));
                s.base  = longint'($urandom) & 64'hFFFF_FFFC;
                s.rs1   = longint'($urandom);
                im      = int'($urandom_range(0, 511)) - 256;
                if ($urandom_range(0, 1) == 1) im = im * 4;
                s.imm   = longint'(im) & 64'hFFFF_FFFF;
                do_cycle(s);
            end
        end
        idle_cycles(3, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drain_a", 32'(q_a.size()), 32'd0);
        check("scoreboard_drain_b", 32'(q_b.size()), 32'd0);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
